// File: rtl/text_glyph_renderer.sv
// Text-screen reader for the 8x8 font ROM: maps each pixel coordinate to a text
// cell, fetches the glyph row through the external ROM and emits pix_on 3 edges later.
module text_glyph_renderer #(
  parameter int COLS        = 16,
  parameter int LINES       = 2,
  parameter int SCALE_SHIFT = 2,
  parameter int X0          = 0,
  parameter int Y0          = 0
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         wr_en,
  input  logic [$clog2(COLS)-1:0]                      wr_col,
  input  logic [((LINES > 1) ? $clog2(LINES) : 1)-1:0] wr_line,
  input  logic [7:0]                                   wr_char,
  input  logic                                         clr,
  output logic                                         busy,
  input  logic                                         pix_valid,
  input  logic [9:0]                                   pix_x,
  input  logic [9:0]                                   pix_y,
  output logic [7:0]                                   font_char,
  output logic [3:0]                                   font_row,
  input  logic [7:0]                                   font_line,
  output logic                                         pix_on,
  output logic                                         pix_on_valid
);

  localparam int          NCELLS    = COLS * LINES;
  localparam int          AW        = (NCELLS > 1) ? $clog2(NCELLS) : 1;
  localparam int          GS        = 3 + SCALE_SHIFT;
  localparam logic [31:0] AREA_W    = 32'(COLS) << GS;
  localparam logic [31:0] AREA_H    = 32'(LINES) << GS;
  localparam logic [AW-1:0] LAST_CELL = AW'(NCELLS - 1);

  logic [7:0]    mem [NCELLS];
  logic [AW-1:0] sweep_r;

  logic [10:0]   dx_s, dy_s;
  logic [9:0]    rx_s, ry_s;
  logic          in_area_s;
  logic [31:0]   cell_col_s, cell_line_s;
  logic [AW-1:0] rd_addr_s;
  logic [2:0]    gx_s, gy_s;

  logic          wr_ok_s;
  logic [AW-1:0] wr_addr_s;

  logic          v1_r, in1_r, v2_r, in2_r, blank2_r;
  logic [2:0]    gx1_r, gy1_r, gx2_r;
  logic [7:0]    char1_r;

  // Coordinate decode; the 11-bit differences' top bit flags pixels left of / above the area.
  always_comb begin
    dx_s        = {1'b0, pix_x} - 11'(X0);
    dy_s        = {1'b0, pix_y} - 11'(Y0);
    rx_s        = dx_s[9:0];
    ry_s        = dy_s[9:0];
    in_area_s   = !dx_s[10] && !dy_s[10] &&
                  ({22'd0, rx_s} < AREA_W) && ({22'd0, ry_s} < AREA_H);
    cell_col_s  = 32'(rx_s >> GS);
    cell_line_s = 32'(ry_s >> GS);
    gx_s        = 3'(rx_s >> SCALE_SHIFT);
    gy_s        = 3'(ry_s >> SCALE_SHIFT);
    if (in_area_s) begin
      rd_addr_s = AW'(cell_line_s * 32'(COLS) + cell_col_s);
    end else begin
      rd_addr_s = {AW{1'b0}};
    end
  end

  // Host write qualification: blocked during a sweep and for out-of-range cells.
  always_comb begin
    wr_ok_s   = wr_en && !busy &&
                (32'(wr_col) < 32'(COLS)) && (32'(wr_line) < 32'(LINES));
    wr_addr_s = AW'(32'(wr_line) * 32'(COLS) + 32'(wr_col));
  end

  // Clear-sweep sequencer; clr restarts from cell 0 even mid-sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= 1'b1;
      sweep_r <= {AW{1'b0}};
    end else if (clr) begin
      busy    <= 1'b1;
      sweep_r <= {AW{1'b0}};
    end else if (busy) begin
      if (sweep_r == LAST_CELL) begin
        busy <= 1'b0;
      end else begin
        sweep_r <= sweep_r + AW'(1);
      end
    end else begin
      sweep_r <= sweep_r;
    end
  end

  // Text buffer write port (not reset; the sweep initialises it).
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[sweep_r] <= 8'd32;
    end else if (wr_ok_s) begin
      mem[wr_addr_s] <= wr_char;
    end
  end

  // Pixel pipeline: edge 1 reads the cell, edge 2 waits on the ROM, edge 3 picks the bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_r         <= 1'b0;
      in1_r        <= 1'b0;
      gx1_r        <= 3'd0;
      gy1_r        <= 3'd0;
      char1_r      <= 8'd32;
      v2_r         <= 1'b0;
      in2_r        <= 1'b0;
      gx2_r        <= 3'd0;
      blank2_r     <= 1'b1;
      pix_on_valid <= 1'b0;
      pix_on       <= 1'b0;
    end else begin
      v1_r         <= pix_valid;
      in1_r        <= in_area_s;
      gx1_r        <= gx_s;
      gy1_r        <= gy_s;
      char1_r      <= mem[rd_addr_s];
      v2_r         <= v1_r;
      in2_r        <= in1_r;
      gx2_r        <= gx1_r;
      blank2_r     <= (char1_r == 8'd32) || char1_r[7];
      pix_on_valid <= v2_r;
      pix_on       <= v2_r && in2_r && !blank2_r && font_line[3'd7 - gx2_r];
    end
  end

  // Codes >= 128 have no glyph, so the ROM is pointed at space instead.
  always_comb begin
    if (char1_r[7]) begin
      font_char = 8'd32;
    end else begin
      font_char = char1_r;
    end
    font_row = {1'b0, gy1_r};
  end

endmodule

// File: tb/tb_text_glyph_renderer.sv
// Bench for text_glyph_renderer: vector table plus hand sequences and random traffic,
// all checked against a cell/glyph reference model and a registered font ROM model.
module tb_text_glyph_renderer;

  localparam int COLS = 16;
  localparam int LINES = 2;
  localparam int S = 2;
  localparam int X0 = 0;
  localparam int Y0 = 0;
  localparam int NC = COLS * LINES;
  localparam int CW = 8 << S;

  logic       clk = 1'b0;
  logic       rst, wr_en, clr, busy, pix_valid, pix_on, pix_on_valid;
  logic [3:0] wr_col;
  logic [0:0] wr_line;
  logic [7:0] wr_char, font_char, font_line;
  logic [9:0] pix_x, pix_y;
  logic [3:0] font_row;

  int n_checks = 0;
  int n_pass = 0;

  logic [7:0] text_m [LINES][COLS];
  int rem_m = 0;
  bit ev [3];
  bit eo [3];
  bit ed [3];

  typedef struct { int x; int y; bit on; } vec_t;
  vec_t vt [12];

  always #5 clk = ~clk;

  text_glyph_renderer #(.COLS(COLS), .LINES(LINES), .SCALE_SHIFT(S), .X0(X0), .Y0(Y0)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_col(wr_col), .wr_line(wr_line),
    .wr_char(wr_char), .clr(clr), .busy(busy), .pix_valid(pix_valid),
    .pix_x(pix_x), .pix_y(pix_y), .font_char(font_char), .font_row(font_row),
    .font_line(font_line), .pix_on(pix_on), .pix_on_valid(pix_on_valid)
  );

  // Font table; space deliberately returns all ones so blanking must come from the DUT.
  function automatic logic [7:0] glyph(input logic [7:0] c, input logic [2:0] r);
    logic [63:0] g;
    case (c)
      8'h31:   g = 64'h1838181818187E00;
      8'h2B:   g = 64'h001818FF18180000;
      8'h30:   g = 64'h3C666E7666663C00;
      8'h38:   g = 64'h3C66663C66663C00;
      8'h37:   g = 64'h7E060C1830303000;
      8'h20:   g = 64'hFFFFFFFFFFFFFFFF;
      default: g = {8{(c * 8'd37) ^ 8'h5A ^ {5'd0, r}}};
    endcase
    return g[8*(7-int'(r)) +: 8];
  endfunction

  always @(posedge clk) font_line <= glyph(font_char, font_row[2:0]);

  function automatic bit model_pix(int x, int y);
    int rx = x - X0;
    int ry = y - Y0;
    logic [7:0] c;
    logic [7:0] g;
    if (rx < 0 || ry < 0 || rx >= COLS * CW || ry >= LINES * CW) return 1'b0;
    c = text_m[ry / CW][rx / CW];
    if (c == 8'd32 || c >= 8'd128) return 1'b0;
    g = glyph(c, 3'((ry >> S) % 8));
    return g[7 - ((rx >> S) % 8)];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One clock: predict from the current inputs, advance the model, then compare after the edge.
  task automatic tick();
    bit dc, inarea, e_on;
    int rx, ry;
    logic [7:0] c, efc;
    logic [3:0] efr;
    rx = int'(pix_x) - X0;
    ry = int'(pix_y) - Y0;
    dc = (rem_m > 0);
    inarea = rx >= 0 && ry >= 0 && rx < COLS * CW && ry < LINES * CW;
    e_on = model_pix(int'(pix_x), int'(pix_y));
    c = inarea ? text_m[ry / CW][rx / CW] : 8'd0;
    efc = (c >= 8'd128) ? 8'd32 : c;
    efr = 4'((ry >> S) % 8);
    ev[2] = ev[1]; ev[1] = ev[0]; ev[0] = pix_valid;
    eo[2] = eo[1]; eo[1] = eo[0]; eo[0] = e_on;
    ed[2] = ed[1]; ed[1] = ed[0]; ed[0] = dc;
    if (rst) begin
      ev[0] = 1'b0; ev[1] = 1'b0; ev[2] = 1'b0;
    end
    if (wr_en && rem_m == 0) text_m[wr_line][wr_col] = wr_char;
    if (rst || clr) rem_m = NC;
    else if (rem_m > 0) begin
      rem_m--;
      if (rem_m == 0)
        for (int l = 0; l < LINES; l++)
          for (int k = 0; k < COLS; k++) text_m[l][k] = 8'd32;
    end
    @(posedge clk);
    #1;
    chk("busy", busy, rem_m > 0);
    chk("pix_on_valid", pix_on_valid, ev[2]);
    if (ev[2] && !ed[2]) chk("pix_on", pix_on, eo[2]);
    if (rst) begin
      chk("rst_font_char", font_char, 8'd32);
      chk("rst_font_row", font_row, 4'd0);
    end else if (pix_valid && inarea && !dc) begin
      chk("font_char", font_char, efc);
      chk("font_row", font_row, efr);
    end
  endtask

  task automatic wr(input int col, input int line, input logic [7:0] ch);
    wr_en = 1'b1; wr_col = 4'(col); wr_line = 1'(line); wr_char = ch;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic probe(input string name, input int x, input int y, input bit exp);
    pix_valid = 1'b1; pix_x = 10'(x); pix_y = 10'(y);
    tick();
    pix_valid = 1'b0;
    tick();
    tick();
    chk({name, "_valid"}, pix_on_valid, 1'b1);
    chk(name, pix_on, exp);
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (busy && n < bound) begin
      tick();
      n++;
    end
    chk("idle_reached", busy, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt;
    logic [7:0] got;
    logic [7:0] gotv;
    int sum;

    vt[0]  = '{12, 0, 1'b1};   vt[1]  = '{0, 0, 1'b0};
    vt[2]  = '{32, 44, 1'b1};  vt[3]  = '{63, 44, 1'b1};
    vt[4]  = '{64, 44, 1'b0};  vt[5]  = '{40, 60, 1'b0};
    vt[6]  = '{524, 0, 1'b0};  vt[7]  = '{12, 64, 1'b0};
    vt[8]  = '{500, 36, 1'b1}; vt[9]  = '{0, 64, 1'b0};
    vt[10] = '{512, 0, 1'b0};  vt[11] = '{488, 56, 1'b1};
    for (int l = 0; l < LINES; l++)
      for (int k = 0; k < COLS; k++) text_m[l][k] = 8'd0;
    for (int i = 0; i < 3; i++) begin ev[i] = 1'b0; eo[i] = 1'b0; ed[i] = 1'b1; end

    rst = 1'b1; wr_en = 1'b0; clr = 1'b0; pix_valid = 1'b0;
    wr_col = 4'd0; wr_line = 1'b0; wr_char = 8'd0; pix_x = 10'd0; pix_y = 10'd0;
    tick();
    chk("reset_pix_on", pix_on, 1'b0);
    chk("reset_busy", busy, 1'b1);
    tick();
    rst = 1'b0;

    // Power-up sweep length, then blank screen
    cnt = 0;
    while (busy && cnt < 100) begin tick(); cnt++; end
    chk("power_up_busy_len", cnt, 32);
    for (int i = 0; i < 4; i++) begin
      pix_valid = 1'b1; pix_x = 10'($urandom_range(0, 511)); pix_y = 10'($urandom_range(0, 63));
      tick();
    end
    pix_valid = 1'b0;
    tick(); tick();
    chk("blank_valid", pix_on_valid, 1'b1);
    chk("blank_pix_on", pix_on, 1'b0);

    wr(0, 0, 8'h31);
    pix_valid = 1'b1; pix_x = 10'd12; pix_y = 10'd0;
    tick();
    pix_valid = 1'b0;
    chk("t2_font_char", font_char, 8'h31);
    chk("t2_font_row", font_row, 4'd0);
    tick(); tick();
    wr(1, 1, 8'd43);
    wr(15, 1, 8'd56);
    for (int i = 0; i < 12; i++) probe($sformatf("vec%0d", i), vt[i].x, vt[i].y, vt[i].on);

    // '+' middle row across a whole cell, then the blank neighbour
    sum = 0;
    for (int i = 0; i < 35; i++) begin
      pix_valid = (i < 33); pix_x = 10'(32 + i); pix_y = 10'd44;
      tick();
      if (i >= 2 && i < 34) sum += int'(pix_on);
      if (i == 34) chk("plus_x64", pix_on, 1'b0);
    end
    chk("plus_row_count", sum, 32);

    wr(0, 0, 8'd48);
    got = 8'd0;
    for (int i = 0; i < 10; i++) begin
      pix_valid = (i < 8); pix_x = 10'(4 * i); pix_y = 10'd0;
      tick();
      if (i >= 2) got = {got[6:0], pix_on};
    end
    chk("zero_row_stream", got, 8'b00111100);
    gotv = 8'd0;
    for (int i = 0; i < 10; i++) begin
      pix_valid = (i < 8) && (i != 3); pix_x = 10'(4 * i); pix_y = 10'd0;
      tick();
      if (i >= 2) gotv = {gotv[6:0], pix_on_valid};
    end
    chk("valid_hole", gotv, 8'b11101111);

    // clr, ignored write during the sweep, clr restart
    pix_valid = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    cnt = 0;
    while (busy && cnt < 200) begin
      wr_en = (cnt == 4); wr_col = 4'd3; wr_line = 1'b0; wr_char = 8'h37;
      clr = (cnt == 9);
      tick();
      wr_en = 1'b0; clr = 1'b0;
      cnt++;
    end
    chk("clr_restart_busy_len", cnt, 42);
    probe("ignored_write_cell", 104, 0, 1'b0);
    probe("cleared_cell0", 8, 0, 1'b0);

    // rst mid-stream drops in-flight pixels
    wr(0, 0, 8'h31);
    for (int i = 0; i < 3; i++) begin pix_valid = 1'b1; pix_x = 10'd12; pix_y = 10'd0; tick(); end
    rst = 1'b1;
    tick();
    chk("rst_mid_valid0", pix_on_valid, 1'b0);
    rst = 1'b0;
    tick();
    chk("rst_mid_valid1", pix_on_valid, 1'b0);
    pix_valid = 1'b0;
    wait_idle(100);

    // Random traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      pix_valid = ($urandom_range(0, 9) < 8);
      pix_x = 10'($urandom_range(0, 639));
      pix_y = 10'($urandom_range(0, 79));
      wr_en = ($urandom_range(0, 4) == 0);
      wr_col = 4'($urandom_range(0, 15));
      wr_line = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 6))
        0: wr_char = 8'h31;
        1: wr_char = 8'h2B;
        2: wr_char = 8'h30;
        3: wr_char = 8'h38;
        4: wr_char = 8'd32;
        5: wr_char = 8'($urandom_range(128, 255));
        default: wr_char = 8'($urandom_range(0, 255));
      endcase
      clr = ($urandom_range(0, 199) == 0);
      tick();
    end
    wr_en = 1'b0; clr = 1'b0; pix_valid = 1'b0;
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
